// File: rtl/led_scanner.sv
// rtl/led_scanner.sv - prescaled LED bounce/rotate/fill/hold pattern scanner
// Optional PWM dimming is enabled by defining LED_SCANNER_PWM_EN.
module led_scanner #(
  parameter int          NUM_LEDS    = 6,
  parameter int unsigned STEP_CYCLES = 2700000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Enable,
  input  logic [1:0]          Mode,
`ifdef LED_SCANNER_PWM_EN
  input  logic [3:0]          Brightness,
`endif
  output logic [NUM_LEDS-1:0] Led,
  output logic                Tick,
  output logic                Wrap
);

  localparam int                  PW        = $clog2(NUM_LEDS) + 1;
  localparam logic [PW-1:0]       LAST      = PW'(NUM_LEDS - 1);
  localparam logic [PW-1:0]       FULL      = PW'(NUM_LEDS);
  localparam logic [PW-1:0]       ONE       = PW'(1);
  localparam logic [31:0]         STEP_LAST = 32'(STEP_CYCLES - 1);
  localparam logic [NUM_LEDS-1:0] POL       = {NUM_LEDS{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    M_BOUNCE = 2'b00,
    M_ROTATE = 2'b01,
    M_FILL   = 2'b10,
    M_HOLD   = 2'b11
  } mode_e;

  mode_e               mode_q;
  logic [31:0]         cnt_q, cnt_d;
  logic [PW-1:0]       pos_q, pos_d, fill_q, fill_d;
  logic                dir_q, dir_d;
  logic                tick_q, tick_d, wrap_q, wrap_d;
  logic [NUM_LEDS-1:0] pat_q, pat_d, led_q, led_d, rst_pat;
  logic                mode_chg, pwm_on, rst_on;

`ifdef LED_SCANNER_PWM_EN
  logic [3:0] pwm_q;
  assign pwm_on = (pwm_q < Brightness);
  assign rst_on = (Brightness != 4'd0);
`else
  assign pwm_on = 1'b1;
  assign rst_on = 1'b1;
`endif

  assign mode_chg = (Mode != mode_q);
  assign rst_pat  = Mode[1] ? '0 : NUM_LEDS'(1);

  always_comb begin
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    fill_d = fill_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (mode_chg) begin
      cnt_d  = '0;
      pos_d  = '0;
      dir_d  = 1'b1;
      fill_d = '0;
    end else if (Enable) begin
      if (cnt_q == STEP_LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        case (mode_q)
          M_BOUNCE: begin
            // Turning at the top and arriving at 0 share the down path;
            // landing on 0 always flips back to up, so N=2 never dwells.
            if (dir_q && pos_q != LAST) begin
              pos_d = pos_q + ONE;
            end else begin
              pos_d  = pos_q - ONE;
              dir_d  = (pos_d == '0);
              wrap_d = (pos_d == '0);
            end
          end
          M_ROTATE: begin
            pos_d  = (pos_q == LAST) ? '0 : pos_q + ONE;
            wrap_d = (pos_q == LAST);
          end
          M_FILL: begin
            fill_d = (fill_q == FULL) ? '0 : fill_q + ONE;
            wrap_d = (fill_q == FULL);
          end
          default: ;
        endcase
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    pat_d = pat_q;
    if (mode_q != M_HOLD) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        pat_d[i] = (mode_q == M_FILL) ? (PW'(i) < fill_q) : (PW'(i) == pos_q);
      end
    end
    led_d = (pat_d & {NUM_LEDS{pwm_on}}) ^ POL;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mode_q <= mode_e'(Mode);
      cnt_q  <= '0;
      pos_q  <= '0;
      dir_q  <= 1'b1;
      fill_q <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      pat_q  <= rst_pat;
      led_q  <= (rst_pat & {NUM_LEDS{rst_on}}) ^ POL;
`ifdef LED_SCANNER_PWM_EN
      pwm_q  <= '0;
`endif
    end else begin
      mode_q <= mode_e'(Mode);
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      fill_q <= fill_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      pat_q  <= pat_d;
      led_q  <= led_d;
`ifdef LED_SCANNER_PWM_EN
      pwm_q  <= pwm_q + 4'd1;
`endif
    end
  end

  assign Led  = led_q;
  assign Tick = tick_q;
  assign Wrap = wrap_q;

endmodule

// File: tb/tb_led_scanner.sv
// tb/tb_led_scanner.sv - scoreboard bench for led_scanner (N=4, 4-cycle steps, active-low)
module tb_led_scanner;
  localparam int N    = 4;
  localparam int STEP = 4;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         Enable = 1'b0;
  logic [1:0]   Mode = 2'b00;
  logic [N-1:0] Led;
  logic         Tick, Wrap;

  led_scanner #(.NUM_LEDS(N), .STEP_CYCLES(STEP), .ACTIVE_LOW(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Mode(Mode),
    .Led(Led), .Tick(Tick), .Wrap(Wrap)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int           cyc;
    bit           wrap;
    logic [N-1:0] led;
  } ev_t;

  ev_t          q[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  bit           mon_on = 1'b0;
  int           mreg, k, en_cnt;
  logic [N-1:0] held;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Logical pattern for step index kk of each mode's cycle.
  function automatic logic [N-1:0] lpat(input int m, input int kk, input logic [N-1:0] h);
    logic [N-1:0] b;
    b = 1;
    case (m)
      0:       return b << ((kk < N) ? kk : 2 * N - 2 - kk);
      1:       return b << kk;
      2:       return (b << kk) - b;
      default: return h;
    endcase
  endfunction

  function automatic int period(input int m);
    case (m)
      0:       return 2 * N - 2;
      1:       return N;
      default: return N + 1;
    endcase
  endfunction

  task automatic model_edge(input bit en, input int md);
    ev_t e;
    if (md != mreg) begin
      if (mreg != 3) held = lpat(mreg, k, held);
      mreg   = md;
      k      = 0;
      en_cnt = 0;
    end else if (en) begin
      en_cnt++;
      if (en_cnt == STEP) begin
        en_cnt = 0;
        if (mreg != 3) k = (k + 1) % period(mreg);
        e.cyc  = cyc;
        e.wrap = (mreg != 3) && (k == 0);
        e.led  = ~lpat(mreg, k, held);
        q.push_back(e);
      end
    end
  endtask

  initial begin
    logic [N-1:0] pend;
    bit           pend_v;
    bit           exp_t;
    pend_v = 1'b0;
    forever begin
      @(negedge Clock);
      if (mon_on) begin
        exp_t = (q.size() > 0) && (q[0].cyc == cyc);
        if (pend_v) begin
          chk("led_after_tick", Led, pend);
          pend_v = 1'b0;
        end
        chk("tick", Tick, exp_t);
        if (exp_t) begin
          chk("wrap", Wrap, q[0].wrap);
          pend   = q[0].led;
          pend_v = 1'b1;
          void'(q.pop_front());
        end else begin
          chk("wrap_idle", Wrap, 0);
        end
      end
    end
  end

  initial begin
    Reset = 1'b1; Mode = 2'b00; Enable = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_led_bounce", Led, 4'b1110);
    chk("rst_tick", Tick, 0);
    chk("rst_wrap", Wrap, 0);
    Mode = 2'b10;
    @(posedge Clock);
    #1;
    chk("rst_led_fill", Led, 4'b1111);
    Mode = 2'b00;
    @(posedge Clock);
    #2 Reset = 1'b0;

    for (int i = 1; i <= 4; i++) begin
      @(posedge Clock);
      #1;
      chk("first_tick", Tick, i == 4);
    end
    repeat (10) @(posedge Clock);
    #1;
    chk("bounce_pos3", Led, 4'b0111);
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_led", Led, 4'b1110);
    chk("async_rst_tick", Tick, 0);

    @(posedge Clock);
    #1 Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clock);
      #1;
      chk("frz_tick", Tick, 0);
      chk("frz_led", Led, 4'b1110);
    end
    Enable = 1'b1;
    @(posedge Clock);
    #1;
    chk("resume_tick_early", Tick, 0);
    @(posedge Clock);
    #1;
    chk("resume_tick", Tick, 1);
    chk("resume_wrap", Wrap, 0);

    Reset  = 1'b1;
    Mode   = 2'($urandom_range(0, 3));
    Enable = 1'b1;
    @(posedge Clock);
    #1;
    mreg   = Mode;
    k      = 0;
    en_cnt = 0;
    held   = '0;
    q.delete();
    cyc    = 0;
    Reset  = 1'b0;
    mon_on = 1'b1;
    for (int c = 0; c < 3003; c++) begin
      @(posedge Clock);
      cyc++;
      model_edge(Enable, Mode);
      #1;
      if (c >= 2999) begin
        Enable = 1'b0;
      end else begin
        Enable = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 49) == 0) Mode = 2'($urandom_range(0, 3));
      end
    end
    @(negedge Clock);
    @(negedge Clock);
    #1 mon_on = 1'b0;
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
